// File: rtl/mem_pkg.sv
// mem_pkg: constants and types shared by the count memory, its write side
// and the read-side controller (mem_reader).
//   MEM_WIDTH  - width of one stored count
//   MEM_DEPTH  - number of entries the memory holds
//   rd_state_t - read controller states
package mem_pkg;

  localparam int MEM_WIDTH = 12;
  localparam int MEM_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    LATCH = 2'd2
  } rd_state_t;

endpackage

// File: rtl/mem_reader_occ_counter.sv
// occ_counter: saturating up/down occupancy counter.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   inc       - add one entry (ignored when already at DEPTH)
//   dec       - remove one entry (ignored when already at zero)
//   count     - registered entry count, 0..DEPTH
//   empty     - registered, count == 0
//   full      - registered, count == DEPTH
module occ_counter #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inc,
  input  logic                       dec,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          empty_reg;
  logic          full_reg;

  // inc and dec together cancel; each direction saturates at its bound.
  always_comb begin
    count_next = count_reg;
    if (inc && !dec && !full_reg) begin
      count_next = count_reg + 1'b1;
    end else if (dec && !inc && !empty_reg) begin
      count_next = count_reg - 1'b1;
    end
  end

  // Flags are registered from count_next so they line up with count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      empty_reg <= 1'b1;
      full_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      empty_reg <= (count_next == '0);
      full_reg  <= (count_next == CW'(DEPTH));
    end
  end

  assign count = count_reg;
  assign empty = empty_reg;
  assign full  = full_reg;

endmodule

// File: rtl/mem_reader.sv
// mem_reader: read-side controller for the count memory. On a show request
// (with entries stored) it issues a one-cycle mem_read strobe, then captures
// the returned word into a held display register. Entries are counted by
// watching the write side's mem_write strobe.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   mem_write   - write strobe into the memory (observed only)
//   mem_out     - memory read data, valid the cycle after mem_read
//   show        - request next stored entry (acted on only in IDLE)
//   mem_read    - one-cycle read strobe per accepted request
//   disp        - last captured entry
//   disp_valid  - an entry has been captured since reset
//   occ, empty  - current entry count and count == 0
//   busy        - read in progress (READ or LATCH)
//   underflow   - one-cycle pulse when show arrives with nothing stored
module mem_reader
  import mem_pkg::*;
#(
  parameter int WIDTH = MEM_WIDTH,
  parameter int DEPTH = MEM_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_write,
  input  logic [WIDTH-1:0]           mem_out,
  input  logic                       show,
  output logic                       mem_read,
  output logic [WIDTH-1:0]           disp,
  output logic                       disp_valid,
  output logic [$clog2(DEPTH+1)-1:0] occ,
  output logic                       empty,
  output logic                       busy,
  output logic                       underflow
);

  rd_state_t        state_reg;
  rd_state_t        state_next;
  logic             mem_read_reg;
  logic             busy_reg;
  logic             underflow_reg;
  logic             underflow_next;
  logic [WIDTH-1:0] disp_reg;
  logic             disp_valid_reg;

  // The strobe being sampled is exactly the cycle the memory pops an entry.
  occ_counter #(
    .DEPTH(DEPTH)
  ) u_occ (
    .clk  (clk),
    .rst  (rst),
    .inc  (mem_write),
    .dec  (mem_read_reg),
    .count(occ),
    .empty(empty),
    .full ()
  );

  always_comb begin
    state_next     = state_reg;
    underflow_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (show && !empty) begin
          state_next = READ;
        end else if (show) begin
          underflow_next = 1'b1;
        end
      end
      READ:    state_next = LATCH;
      LATCH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobe and busy are registered from the next state so they are true
  // flops that still coincide with the READ / READ+LATCH cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      mem_read_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      underflow_reg  <= 1'b0;
      disp_reg       <= '0;
      disp_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mem_read_reg  <= (state_next == READ);
      busy_reg      <= (state_next != IDLE);
      underflow_reg <= underflow_next;
      if (state_reg == LATCH) begin
        disp_reg       <= mem_out;
        disp_valid_reg <= 1'b1;
      end
    end
  end

  assign mem_read   = mem_read_reg;
  assign busy       = busy_reg;
  assign underflow  = underflow_reg;
  assign disp       = disp_reg;
  assign disp_valid = disp_valid_reg;

endmodule

// File: tb/tb_mem_reader.sv
// tb_mem_reader: self-checking bench for mem_reader. A small LIFO memory
// model answers mem_read strobes; expected display values are queued when a
// show is driven and compared when the capture lands.
module tb_mem_reader;
  import mem_pkg::*;

  localparam int W  = MEM_WIDTH;
  localparam int D  = MEM_DEPTH;
  localparam int OW = $clog2(D + 1);

  logic          tb_clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_write = 1'b0;
  logic          show = 1'b0;
  logic [W-1:0]  wdata = '0;
  logic [W-1:0]  mem_out;
  logic          mem_read;
  logic [W-1:0]  disp;
  logic          disp_valid;
  logic [OW-1:0] occ;
  logic          empty;
  logic          busy;
  logic          underflow;

  int total = 0;
  int bad   = 0;
  int rd_count = 0;
  int cap_cd = 0;

  logic [W-1:0] exp_model[$];   // driver-side view of stored entries
  logic [W-1:0] sb[$];          // expected captures, oldest first

  always #5 tb_clk = ~tb_clk;

  mem_reader #(
    .WIDTH(W),
    .DEPTH(D)
  ) dut (
    .clk       (tb_clk),
    .rst       (rst),
    .mem_write (mem_write),
    .mem_out   (mem_out),
    .show      (show),
    .mem_read  (mem_read),
    .disp      (disp),
    .disp_valid(disp_valid),
    .occ       (occ),
    .empty     (empty),
    .busy      (busy),
    .underflow (underflow)
  );

  // LIFO memory: read returns the most recent entry on the next cycle.
  logic [W-1:0] stack[D];
  int sp;
  always @(posedge tb_clk) begin
    if (rst) begin
      sp      <= 0;
      mem_out <= '0;
    end else begin
      if (mem_read && sp > 0) mem_out <= stack[sp-1];
      if (mem_write && mem_read && sp > 0) stack[sp-1] <= wdata;
      else if (mem_write && !mem_read && sp < D) stack[sp] <= wdata;
      sp <= sp + ((mem_write && !mem_read && sp < D) ? 1 : 0)
               - ((mem_read && !mem_write && sp > 0) ? 1 : 0);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end else begin
      $display("ok   %s got=%0d", tag, got);
    end
  endtask

  // Monitor on the falling edge: counts strobes and checks each capture
  // two cycles after its strobe against the scoreboard.
  initial begin
    forever begin
      @(negedge tb_clk);
      if (rst) begin
        cap_cd = 0;
        sb.delete();
      end else if (mem_read) begin
        rd_count++;
        cap_cd = 2;
      end else if (cap_cd > 0) begin
        cap_cd--;
        if (cap_cd == 0) begin
          if (sb.size() == 0) begin
            check_val("sb_unexpected_capture", 32'(disp), 32'hFFFF_FFFF);
          end else begin
            check_val("sb_disp", 32'(disp), 32'(sb.pop_front()));
            check_val("sb_disp_valid", 32'(disp_valid), 32'd1);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge tb_clk);
      #1;
    end
  endtask

  task automatic do_write(input logic [W-1:0] val);
    mem_write = 1'b1;
    wdata     = val;
    if (exp_model.size() < D) exp_model.push_back(val);
    tick(1);
    mem_write = 1'b0;
  endtask

  // Single-cycle show pulse; expectation queued if something is stored.
  task automatic show_pulse();
    show = 1'b1;
    if (exp_model.size() > 0) sb.push_back(exp_model.pop_back());
    tick(1);
    show = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    exp_model.delete();
    tick(n);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_before;
    tick(1);
    do_reset(2);
    check_val("rst_disp", 32'(disp), 32'd0);
    check_val("rst_disp_valid", 32'(disp_valid), 32'd0);
    check_val("rst_occ", 32'(occ), 32'd0);
    check_val("rst_empty", 32'(empty), 32'd1);
    check_val("rst_mem_read", 32'(mem_read), 32'd0);

    // Two writes, then one show: most recent (100) comes out first.
    do_write(12'd200);
    do_write(12'd100);
    check_val("occ_after_2w", 32'(occ), 32'd2);
    rd_before = rd_count;
    show_pulse();
    check_val("read_strobe", 32'(mem_read), 32'd1);
    check_val("busy_read", 32'(busy), 32'd1);
    tick(1);
    check_val("strobe_one_cycle", 32'(mem_read), 32'd0);
    check_val("occ_after_read", 32'(occ), 32'd1);
    check_val("busy_latch", 32'(busy), 32'd1);
    tick(1);
    check_val("disp_100", 32'(disp), 32'd100);
    check_val("disp_valid_1", 32'(disp_valid), 32'd1);
    check_val("busy_done", 32'(busy), 32'd0);
    tick(1);
    check_val("one_strobe", 32'(rd_count - rd_before), 32'd1);

    // Second show drains the memory.
    show_pulse();
    tick(2);
    check_val("disp_200", 32'(disp), 32'd200);
    check_val("occ_zero", 32'(occ), 32'd0);
    check_val("empty_again", 32'(empty), 32'd1);
    tick(1);

    // Third show on empty: underflow pulse, no strobe, disp held.
    rd_before = rd_count;
    show_pulse();
    check_val("underflow_pulse", 32'(underflow), 32'd1);
    check_val("no_strobe_empty", 32'(mem_read), 32'd0);
    tick(1);
    check_val("underflow_cleared", 32'(underflow), 32'd0);
    check_val("disp_held", 32'(disp), 32'd200);
    tick(2);
    check_val("no_read_on_underflow", 32'(rd_count - rd_before), 32'd0);

    // Saturation: nine writes into eight entries.
    for (int i = 0; i < 9; i++) do_write(W'(10 + i));
    check_val("occ_saturated", 32'(occ), 32'(D));
    check_val("not_empty_full", 32'(empty), 32'd0);

    // Write coinciding with the read strobe leaves occ unchanged.
    show_pulse();
    mem_write = 1'b1;
    wdata     = 12'd777;
    exp_model.push_back(12'd777);
    tick(1);
    mem_write = 1'b0;
    check_val("occ_rw_same_cycle", 32'(occ), 32'(D));
    tick(3);

    // Held show with five entries: one strobe every third cycle.
    do_reset(1);
    for (int i = 0; i < 5; i++) do_write(W'(300 + 7 * i));
    rd_before = rd_count;
    show = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i % 3 == 0) sb.push_back(exp_model.pop_back());
      tick(1);
      check_val($sformatf("held_strobe_%0d", i), 32'(mem_read), 32'((i % 3) == 0));
    end
    show = 1'b0;
    tick(2);
    check_val("held_three_strobes", 32'(rd_count - rd_before), 32'd3);
    check_val("held_occ", 32'(occ), 32'd2);

    // Reset while in LATCH abandons the capture.
    show_pulse();
    tick(1);
    check_val("in_latch_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    exp_model.delete();
    tick(1);
    check_val("midrst_disp", 32'(disp), 32'd0);
    check_val("midrst_disp_valid", 32'(disp_valid), 32'd0);
    check_val("midrst_occ", 32'(occ), 32'd0);
    check_val("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    rd_before = rd_count;
    tick(4);
    check_val("midrst_no_read", 32'(rd_count - rd_before), 32'd0);
    check_val("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
